// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - CPU-side and memory-side signal bundle for dcache_ctrl
//
// Purpose: groups the MEM-stage access port and the main-memory block port
// of the data cache controller into one bundle.
// Ports (signals):
//   cpu_req_i/cpu_we_i/cpu_addr_i/cpu_wdata_i  pipeline access request
//   cpu_rdata_o/cpu_stall_o                    load data and pipeline freeze
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  block read/write request
//   mem_rdata_i/mem_ack_i                      block read data, completion pulse
// Modports: slave = the cache controller, master = pipeline/memory side.

interface dcache_ctrl_if;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [127:0] mem_rdata_i;
  logic         mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back data cache controller
//
// Purpose: 16-line direct-mapped, write-back, write-allocate data cache with
// 16-byte lines. Loads hit combinationally; misses stall the pipeline while a
// dirty victim is written back and the missing block is refilled.
// Ports:
//   clk_i  clock, rising edge active
//   rst_i  asynchronous active-low reset
//   bus    dcache_ctrl_if.slave (CPU access port and memory block port)

module dcache_ctrl #(
  parameter int NUM_LINES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [23:0]          tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];

  // Block address (addr[31:4]) of the access that missed. Captured so the
  // memory transaction keeps a stable target even if cpu_req_i drops mid-miss.
  logic [27:0] miss_blk_q;

  logic [23:0] req_tag;
  logic [3:0]  req_idx;
  logic [1:0]  req_word;
  logic [3:0]  miss_idx;
  logic        hit;
  logic        miss;
  logic        victim_dirty;
  logic        store_hit;
  logic [31:0] sel_word;
  logic        unused_ok;

  assign req_tag      = bus.cpu_addr_i[31:8];
  assign req_idx      = bus.cpu_addr_i[7:4];
  assign req_word     = bus.cpu_addr_i[3:2];
  assign miss_idx     = miss_blk_q[3:0];
  assign unused_ok    = ^bus.cpu_addr_i[1:0];

  // valid_q is cleared asynchronously, so during reset every access misses
  // and the stall simply follows cpu_req_i.
  assign hit          = bus.cpu_req_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign miss         = bus.cpu_req_i & ~hit;
  assign victim_dirty = valid_q[req_idx] & dirty_q[req_idx];
  assign store_hit    = (state_q == IDLE) & hit & bus.cpu_we_i;
  assign sel_word     = data_q[req_idx][{req_word, 5'd0} +: 32];

  // State register and line status bits
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (store_hit) begin
        dirty_q[req_idx] <= 1'b1;
      end
      if (state_q == WRITEBACK && bus.mem_ack_i) begin
        dirty_q[miss_idx] <= 1'b0;
      end
      if (state_q == ALLOCATE && bus.mem_ack_i) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end
    end
  end

  // Tag/data arrays and miss address hold no state that matters until a
  // valid bit is set, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && miss) begin
      miss_blk_q <= bus.cpu_addr_i[31:4];
    end
    if (store_hit) begin
      data_q[req_idx][{req_word, 5'd0} +: 32] <= bus.cpu_wdata_i;
    end
    if (state_q == ALLOCATE && bus.mem_ack_i) begin
      data_q[miss_idx] <= bus.mem_rdata_i;
      tag_q[miss_idx]  <= miss_blk_q[27:4];
    end
  end

  // Next state and outputs
  always_comb begin
    state_d         = state_q;
    bus.cpu_stall_o = 1'b0;
    bus.cpu_rdata_o = '0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    unique case (state_q)
      IDLE: begin
        bus.cpu_stall_o = miss;
        if (hit && !bus.cpu_we_i) begin
          bus.cpu_rdata_o = sel_word;
        end
        if (miss) begin
          state_d = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.cpu_stall_o = 1'b1;
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = {tag_q[miss_idx], miss_idx, 4'b0000};
        bus.mem_wdata_o = data_q[miss_idx];
        if (bus.mem_ack_i) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        bus.cpu_stall_o = 1'b1;
        bus.mem_req_o   = 1'b1;
        bus.mem_addr_o  = {miss_blk_q, 4'b0000};
        if (bus.mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard testbench for dcache_ctrl
//
// Purpose: drives directed CPU accesses, models main memory, and checks
// memory transactions and load data against queued expectations.
// Ports: none (top-level bench).

module tb_dcache_ctrl;

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mem_exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   ack_delay;
  int   wait_cnt;
  bit   mon_en;
  bit   prev_req;
  bit   prev_we;
  logic [31:0] prev_addr;

  mem_exp_t    mem_q[$];
  logic [31:0] rd_q[$];

  dcache_ctrl_if bus ();

  dcache_ctrl #(.NUM_LINES(16)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory word i of the block at address a is {a[15:0], 16'h1100 + i}.
  function automatic logic [127:0] fill(input logic [31:0] a);
    logic [127:0] v;
    for (int i = 0; i < 4; i++) begin
      v[i*32 +: 32] = {a[15:0], 16'h1100 + 16'(i)};
    end
    return v;
  endfunction

  // Memory model: acks a request after ack_delay cycles with it held.
  always @(negedge clk) begin
    if (bus.mem_ack_i) begin
      bus.mem_ack_i = 1'b0;
      wait_cnt      = 0;
    end
    if (bus.mem_req_o) begin
      if (wait_cnt >= ack_delay) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = fill(bus.mem_addr_o);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a new memory
  // request or completes a load.
  always @(negedge clk) begin
    if (mon_en) begin
      bit new_req;
      new_req = bus.mem_req_o && (!prev_req || (bus.mem_we_o != prev_we) ||
                                  (bus.mem_addr_o != prev_addr));
      if (new_req) begin
        if (mem_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_unexpected: got request addr %0h expected none", bus.mem_addr_o);
        end else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          check("mem_we", 128'(bus.mem_we_o), 128'(e.we));
          check("mem_addr", 128'(bus.mem_addr_o), 128'(e.addr));
          if (e.we) check("mem_wdata", bus.mem_wdata_o, e.wdata);
        end
      end else if (bus.mem_req_o) begin
        check("hold_stall", 128'(bus.cpu_stall_o), 128'd1);
      end else begin
        check("idle_mem_addr_zero", 128'(bus.mem_addr_o), 128'd0);
        check("idle_mem_wdata_zero", bus.mem_wdata_o, 128'd0);
      end
      if (bus.cpu_req_i && !bus.cpu_stall_o && !bus.cpu_we_i) begin
        if (rd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got load data %0h expected none", bus.cpu_rdata_o);
        end else begin
          check("load_rdata", 128'(bus.cpu_rdata_o), 128'(rd_q.pop_front()));
        end
      end else begin
        check("rdata_zero", 128'(bus.cpu_rdata_o), 128'd0);
      end
      prev_req  = bus.mem_req_o;
      prev_we   = bus.mem_we_o;
      prev_addr = bus.mem_addr_o;
    end
  end

  task automatic push_mem(input bit we, input logic [31:0] addr, input logic [127:0] wdata);
    mem_exp_t e;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    mem_q.push_back(e);
  endtask

  // One CPU access; counts stall cycles until the access completes.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_stall, input logic [31:0] exp_rd);
    int n;
    @(posedge clk);
    #1;
    if (!we) rd_q.push_back(exp_rd);
    bus.cpu_req_i   = 1'b1;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (n == 0) check("first_cycle_stall", 128'(bus.cpu_stall_o), 128'(exp_stall > 0));
      if (!bus.cpu_stall_o) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL access_timeout: got %0d stall cycles expected %0d", n, exp_stall);
        break;
      end
    end
    check("stall_cycles", 128'(n), 128'(exp_stall));
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b0;
    bus.cpu_we_i  = 1'b0;
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    ack_delay = 0;
    wait_cnt  = 0;
    mon_en    = 1'b0;
    prev_req  = 1'b0;
    prev_we   = 1'b0;
    prev_addr = '0;
    bus.cpu_req_i   = 1'b0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_wdata_i = '0;
    bus.mem_rdata_i = '0;
    bus.mem_ack_i   = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state: every access misses, no memory request
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h0000_0104;
    #1;
    check("rst_stall_req1", 128'(bus.cpu_stall_o), 128'd1);
    check("rst_mem_req", 128'(bus.mem_req_o), 128'd0);
    check("rst_mem_we", 128'(bus.mem_we_o), 128'd0);
    bus.cpu_req_i = 1'b0;
    #1;
    check("rst_stall_req0", 128'(bus.cpu_stall_o), 128'd0);
    check("rst_rdata", 128'(bus.cpu_rdata_o), 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Cold load: clean miss, refill 0x100, returns word 1
    push_mem(1'b0, 32'h0000_0100, '0);
    access(1'b0, 32'h0000_0104, '0, 2, 32'h0100_1101);
    // Store hit, then read it back, then neighbouring word
    access(1'b1, 32'h0000_0108, 32'hDEAD_BEEF, 0, '0);
    access(1'b0, 32'h0000_0108, '0, 0, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0100, '0, 0, 32'h0100_1100);
    // Same index, new tag: dirty miss writes back the merged line first
    push_mem(1'b1, 32'h0000_0100, {32'h0100_1103, 32'hDEAD_BEEF, 32'h0100_1101, 32'h0100_1100});
    push_mem(1'b0, 32'h0000_0200, '0);
    access(1'b0, 32'h0000_0204, '0, 3, 32'h0200_1101);
    // Store hit on the refilled line, read back
    access(1'b1, 32'h0000_020C, 32'h1234_5678, 0, '0);
    access(1'b0, 32'h0000_020C, '0, 0, 32'h1234_5678);
    // Slow memory: ack held off 10 cycles in both WRITEBACK and ALLOCATE
    ack_delay = 10;
    push_mem(1'b1, 32'h0000_0200, {32'h1234_5678, 32'h0200_1102, 32'h0200_1101, 32'h0200_1100});
    push_mem(1'b0, 32'h0000_0300, '0);
    access(1'b0, 32'h0000_030C, '0, 23, 32'h0300_1103);
    // Store miss to a cold line: refill then merge
    ack_delay = 0;
    push_mem(1'b0, 32'h0000_01F0, '0);
    access(1'b1, 32'h0000_01F8, 32'hCAFE_F00D, 2, '0);
    access(1'b0, 32'h0000_01F8, '0, 0, 32'hCAFE_F00D);

    // Reset pulsed mid-WRITEBACK aborts the transaction and discards dirty data
    ack_delay = 5;
    push_mem(1'b1, 32'h0000_01F0, {32'h01F0_1103, 32'hCAFE_F00D, 32'h01F0_1101, 32'h01F0_1100});
    @(posedge clk);
    #1;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h0000_05F4;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_o && bus.mem_we_o) break;
      n++;
      if (n > 20) begin
        total++;
        bad++;
        $display("FAIL wb_timeout: got no writeback expected writeback within %0d cycles", n);
        break;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_wb_mem_req", 128'(bus.mem_req_o), 128'd0);
    check("rst_wb_mem_we", 128'(bus.mem_we_o), 128'd0);
    check("rst_wb_stall", 128'(bus.cpu_stall_o), 128'd1);
    bus.cpu_req_i = 1'b0;
    #1;
    check("rst_wb_stall_noreq", 128'(bus.cpu_stall_o), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    // Both lines are invalid after reset; dirty store data was dropped
    push_mem(1'b0, 32'h0000_0100, '0);
    access(1'b0, 32'h0000_0100, '0, 2, 32'h0100_1100);
    push_mem(1'b0, 32'h0000_01F0, '0);
    access(1'b0, 32'h0000_01F8, '0, 2, 32'h01F0_1102);

    repeat (3) @(posedge clk);
    check("mem_q_empty", 128'(mem_q.size()), 128'd0);
    check("rd_q_empty", 128'(rd_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
